// File: rtl/risky_run_ctrl_pkg.sv
// Shared types and constants for the risky run controller.
// Holds the FSM state encoding, the default tohost address and a saturating-increment helper.
package risky_run_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReset,
    StRun,
    StDone
  } run_state_t;

  localparam logic [31:0] TOHOST_ADDR_DEF = 32'h0000_1000;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic en);
    return (en && (val != '1)) ? val + 32'd1 : val;
  endfunction

endpackage

// File: rtl/risky_watchdog.sv
// Retire watchdog: counts consecutive cycles without forward progress.
// Fires expire_o on the non-progress cycle that completes LIMIT stalled cycles in a row.
module risky_watchdog #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic progress_i,
  output logic expire_o
);

  localparam int unsigned CntW = $clog2(LIMIT);
  localparam logic [CntW-1:0] CntLast = CntW'(LIMIT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!en_i || progress_i) begin
      cnt_d = '0;
    end else if (cnt_q != CntLast) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_comb begin
    expire_o = en_i && !progress_i && (cnt_q == CntLast);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/risky_run_ctrl.sv
// Run controller for the risky core: sequences core reset, then bounds the run by cycle budget,
// tohost halt store and retire watchdog, latching the outcome until the next start.
module risky_run_ctrl
  import risky_run_ctrl_pkg::*;
#(
  parameter int unsigned    XLEN        = 32,
  parameter int unsigned    RST_CYCLES  = 2,
  parameter int unsigned    MAX_CYCLES  = 100,
  parameter int unsigned    STALL_LIMIT = 16,
  parameter logic [XLEN-1:0] TOHOST_ADDR = XLEN'(TOHOST_ADDR_DEF)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic            core_rst_n,
  input  logic            retire_valid,
  input  logic [XLEN-1:0] retire_pc,
  input  logic            st_en,
  input  logic [XLEN-1:0] st_addr,
  input  logic [XLEN-1:0] st_data,
  output logic            running,
  output logic            done,
  output logic            pass,
  output logic            timeout,
  output logic            hang,
  output logic [XLEN-1:0] exit_code,
  output logic [31:0]     cycle_count,
  output logic [31:0]     retire_count
);

  localparam logic [31:0] RstLast   = 32'(RST_CYCLES - 1);
  localparam logic [31:0] CycleLast = 32'(MAX_CYCLES - 1);

  run_state_t      state_q, state_d;
  logic [31:0]     rst_cnt_q, rst_cnt_d;
  logic [31:0]     cycle_q, cycle_d;
  logic [31:0]     retire_q, retire_d;
  logic [XLEN-1:0] last_pc_q, last_pc_d;
  logic            last_pc_vld_q, last_pc_vld_d;
  logic            pass_q, pass_d;
  logic            timeout_q, timeout_d;
  logic            hang_q, hang_d;
  logic [XLEN-1:0] exit_q, exit_d;

  logic in_run;
  logic progress;
  logic wd_expire;
  logic tohost_evt;
  logic restart;

  assign in_run = (state_q == StRun);
  // A repeated PC (e.g. a jal x0,0 self-loop) is not progress.
  assign progress   = retire_valid && (!last_pc_vld_q || (retire_pc != last_pc_q));
  assign tohost_evt = st_en && (st_addr == TOHOST_ADDR) && st_data[0];
  assign restart    = start && ((state_q == StIdle) || (state_q == StDone));

  risky_watchdog #(
    .LIMIT(STALL_LIMIT)
  ) u_watchdog (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .en_i      (in_run),
    .progress_i(progress),
    .expire_o  (wd_expire)
  );

  always_comb begin
    state_d       = state_q;
    rst_cnt_d     = rst_cnt_q;
    cycle_d       = cycle_q;
    retire_d      = retire_q;
    last_pc_d     = last_pc_q;
    last_pc_vld_d = last_pc_vld_q;
    pass_d        = pass_q;
    timeout_d     = timeout_q;
    hang_d        = hang_q;
    exit_d        = exit_q;

    unique case (state_q)
      StIdle: ;
      StReset: begin
        if (rst_cnt_q == RstLast) begin
          state_d = StRun;
        end else begin
          rst_cnt_d = rst_cnt_q + 32'd1;
        end
      end
      StRun: begin
        cycle_d  = sat_inc(cycle_q, 1'b1);
        retire_d = sat_inc(retire_q, retire_valid);
        if (retire_valid) begin
          last_pc_d     = retire_pc;
          last_pc_vld_d = 1'b1;
        end
        if (tohost_evt) begin
          exit_d  = st_data >> 1;
          pass_d  = (st_data[XLEN-1:1] == '0);
          state_d = StDone;
        end else if (wd_expire) begin
          hang_d  = 1'b1;
          state_d = StDone;
        end else if (cycle_q == CycleLast) begin
          timeout_d = 1'b1;
          state_d   = StDone;
        end
      end
      StDone: ;
      default: state_d = StIdle;
    endcase

    if (restart) begin
      state_d       = StReset;
      rst_cnt_d     = '0;
      cycle_d       = '0;
      retire_d      = '0;
      last_pc_d     = '0;
      last_pc_vld_d = 1'b0;
      pass_d        = 1'b0;
      timeout_d     = 1'b0;
      hang_d        = 1'b0;
      exit_d        = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      rst_cnt_q     <= '0;
      cycle_q       <= '0;
      retire_q      <= '0;
      last_pc_q     <= '0;
      last_pc_vld_q <= 1'b0;
      pass_q        <= 1'b0;
      timeout_q     <= 1'b0;
      hang_q        <= 1'b0;
      exit_q        <= '0;
    end else begin
      state_q       <= state_d;
      rst_cnt_q     <= rst_cnt_d;
      cycle_q       <= cycle_d;
      retire_q      <= retire_d;
      last_pc_q     <= last_pc_d;
      last_pc_vld_q <= last_pc_vld_d;
      pass_q        <= pass_d;
      timeout_q     <= timeout_d;
      hang_q        <= hang_d;
      exit_q        <= exit_d;
    end
  end

  assign core_rst_n   = in_run;
  assign running      = in_run;
  assign done         = (state_q == StDone);
  assign pass         = pass_q;
  assign timeout      = timeout_q;
  assign hang         = hang_q;
  assign exit_code    = exit_q;
  assign cycle_count  = cycle_q;
  assign retire_count = retire_q;

endmodule

// File: tb/tb_risky_run_ctrl.sv
// Randomized bench for risky_run_ctrl: per-run stimulus tables are scored against a
// cycle-list model of the run rules (budget, tohost halt, consecutive-stall hang).
module tb_risky_run_ctrl;

  localparam int unsigned RSTC  = 2;
  localparam int unsigned MAXC  = 100;
  localparam int unsigned STALL = 16;
  localparam logic [31:0] TOHOST = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        rv = 1'b0;
  logic [31:0] rpc = '0;
  logic        st_en = 1'b0;
  logic [31:0] st_addr = '0;
  logic [31:0] st_data = '0;

  logic        core_rst_n, running, done, pass, timeout, hang;
  logic [31:0] exit_code, cycle_count, retire_count;

  risky_run_ctrl #(
    .XLEN       (32),
    .RST_CYCLES (RSTC),
    .MAX_CYCLES (MAXC),
    .STALL_LIMIT(STALL),
    .TOHOST_ADDR(TOHOST)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .core_rst_n  (core_rst_n),
    .retire_valid(rv),
    .retire_pc   (rpc),
    .st_en       (st_en),
    .st_addr     (st_addr),
    .st_data     (st_data),
    .running     (running),
    .done        (done),
    .pass        (pass),
    .timeout     (timeout),
    .hang        (hang),
    .exit_code   (exit_code),
    .cycle_count (cycle_count),
    .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Per-run stimulus tables, one entry per RUN cycle.
  logic        s_rv     [MAXC];
  logic [31:0] s_pc     [MAXC];
  logic        s_st_en  [MAXC];
  logic [31:0] s_st_addr[MAXC];
  logic [31:0] s_st_data[MAXC];

  // Expected outcome.
  int          e_len;
  int          e_ret;
  bit          e_pass, e_to, e_hang;
  logic [31:0] e_exit;

  task automatic model_run();
    int          stall = 0;
    bit          have = 0;
    logic [31:0] last = '0;
    e_len = 0; e_ret = 0; e_pass = 0; e_to = 0; e_hang = 0; e_exit = '0;
    for (int i = 0; i < int'(MAXC); i++) begin
      bit prog;
      if (s_rv[i]) e_ret++;
      prog = s_rv[i] && (!have || s_pc[i] != last);
      if (s_rv[i]) begin
        last = s_pc[i];
        have = 1;
      end
      stall = prog ? 0 : stall + 1;
      e_len = i + 1;
      if (s_st_en[i] && s_st_addr[i] == TOHOST && s_st_data[i][0]) begin
        e_exit = s_st_data[i] >> 1;
        e_pass = (e_exit == 0);
        return;
      end
      if (stall >= int'(STALL)) begin
        e_hang = 1;
        return;
      end
      if (i + 1 >= int'(MAXC)) begin
        e_to = 1;
        return;
      end
    end
  endtask

  // Modes: 0 no retires, 1 steady progress, 2 random, 3 pass at 10,
  // 4 ignored even store then failing exit, 5 pass on budget cycle.
  task automatic gen_stim(input int mode);
    logic [31:0] pc = 32'h200 + ($urandom % 64) * 4;
    bit          stalling = 0;
    for (int i = 0; i < int'(MAXC); i++) begin
      s_st_en[i]   = 1'b0;
      s_st_addr[i] = ($urandom % 2 == 0) ? TOHOST : $urandom;
      s_st_data[i] = $urandom | 32'h1;
      if (mode == 0) begin
        s_rv[i] = 1'b0;
        s_pc[i] = pc;
      end else if (mode == 2) begin
        if ($urandom % 16 == 0) stalling = !stalling;
        s_rv[i] = ($urandom % 4 != 0);
        if (!stalling && s_rv[i]) pc = ($urandom % 2 == 0) ? pc + 4 : ($urandom & ~32'h3);
        s_pc[i]      = pc;
        s_st_en[i]   = ($urandom % 8 == 0);
        s_st_addr[i] = ($urandom % 3 == 0) ? TOHOST :
                       (($urandom % 2 == 0) ? TOHOST + 4 : $urandom);
        s_st_data[i] = $urandom % 8;
      end else begin
        s_rv[i] = 1'b1;
        pc      = pc + 4;
        s_pc[i] = pc;
      end
    end
    if (mode == 3) begin
      s_st_en[10] = 1'b1; s_st_addr[10] = TOHOST; s_st_data[10] = 32'd1;
    end
    if (mode == 4) begin
      s_st_en[5]  = 1'b1; s_st_addr[5]  = TOHOST; s_st_data[5]  = 32'd6;
      s_st_en[20] = 1'b1; s_st_addr[20] = TOHOST; s_st_data[20] = 32'd7;
    end
    if (mode == 5) begin
      s_st_en[MAXC-1] = 1'b1; s_st_addr[MAXC-1] = TOHOST; s_st_data[MAXC-1] = 32'd1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_junk();
    rv = 1'b1; rpc = 32'hdead_0000; st_en = 1'b1; st_addr = TOHOST; st_data = 32'd3;
  endtask

  // Pulse start and walk through RESET; leaves the DUT in its first RUN cycle.
  task automatic start_run();
    int n = 0;
    bit low_ok = 1;
    start = 1'b1;
    step();
    start = 1'b0;
    drive_junk();
    check_eq("restart_cycle_cnt", cycle_count, 32'd0);
    check_eq("restart_retire_cnt", retire_count, 32'd0);
    check_eq("restart_done", 32'(done), 32'd0);
    while (!running && n < 10) begin
      if (core_rst_n !== 1'b0) low_ok = 0;
      step();
      n++;
    end
    check_eq("reset_len", 32'(n), 32'(RSTC));
    check_eq("reset_core_low", 32'(low_ok), 32'd1);
    check_eq("run_core_rst_n", 32'(core_rst_n), 32'd1);
  endtask

  task automatic do_run(input int mode);
    int i = 0;
    gen_stim(mode);
    model_run();
    start_run();
    while (i < int'(MAXC) + 5) begin
      if (i < int'(MAXC)) begin
        rv = s_rv[i]; rpc = s_pc[i];
        st_en = s_st_en[i]; st_addr = s_st_addr[i]; st_data = s_st_data[i];
      end else begin
        rv = 1'b0; st_en = 1'b0;
      end
      start = ($urandom % 10 == 0);
      step();
      i++;
      if (done) break;
    end
    start = 1'b0;
    check_eq("run_len", 32'(i), 32'(e_len));
    check_eq("done", 32'(done), 32'd1);
    check_eq("pass", 32'(pass), 32'(e_pass));
    check_eq("timeout", 32'(timeout), 32'(e_to));
    check_eq("hang", 32'(hang), 32'(e_hang));
    check_eq("exit_code", exit_code, e_exit);
    check_eq("cycle_count", cycle_count, 32'(e_len));
    check_eq("retire_count", retire_count, 32'(e_ret));
    check_eq("done_core_rst_n", 32'(core_rst_n), 32'd0);
    check_eq("done_running", 32'(running), 32'd0);
    drive_junk();
    repeat (3) step();
    check_eq("hold_cycle_count", cycle_count, 32'(e_len));
    check_eq("hold_retire_count", retire_count, 32'(e_ret));
    check_eq("hold_done", 32'(done), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "bench time limit expired");
  end

  initial begin
    #2 rst_n = 1'b0;
    #10;
    check_eq("rst_core_rst_n", 32'(core_rst_n), 32'd0);
    check_eq("rst_running", 32'(running), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_flags", {29'd0, pass, timeout, hang}, 32'd0);
    check_eq("rst_exit_code", exit_code, 32'd0);
    check_eq("rst_cycle_count", cycle_count, 32'd0);
    check_eq("rst_retire_count", retire_count, 32'd0);
    step();
    rst_n = 1'b1;
    drive_junk();
    repeat (3) step();
    check_eq("idle_no_start", 32'(running), 32'd0);
    check_eq("idle_cycle_count", cycle_count, 32'd0);

    do_run(0);
    do_run(1);
    do_run(3);
    do_run(4);
    do_run(5);
    for (int k = 0; k < 25; k++) do_run(2);

    // Asynchronous reset mid-run, then a clean restart.
    gen_stim(1);
    start_run();
    for (int i = 0; i < 30; i++) begin
      rv = s_rv[i]; rpc = s_pc[i]; st_en = 1'b0;
      step();
    end
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_running", 32'(running), 32'd0);
    check_eq("async_core_rst_n", 32'(core_rst_n), 32'd0);
    check_eq("async_cycle_count", cycle_count, 32'd0);
    check_eq("async_done", 32'(done), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    do_run(3);
    do_run(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
